// File: rtl/pwm_deadtime.sv
// Dead-time insertion stage: turns one PWM waveform into a complementary high/low gate pair
// with programmable dead bands, short-pulse swallowing and a latched fault shutdown.
module pwm_deadtime #(
  parameter int DT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pwm_in,
  input  logic                enable,
  input  logic [DT_WIDTH-1:0] rise_dly,
  input  logic [DT_WIDTH-1:0] fall_dly,
  input  logic                fault,
  input  logic                fault_clr,
  output logic                hs,
  output logic                ls,
  output logic                fault_latched,
  output logic                short_pulse
);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_LS_ON    = 3'd1,
    ST_DT_TO_HS = 3'd2,
    ST_HS_ON    = 3'd3,
    ST_DT_TO_LS = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                pwm_q;
  logic                swallow_s;
  logic                hs_q, ls_q, fault_latched_q, short_pulse_q;

  // A delay of zero is treated as one clock, so the load value is max(dly,1)-1.
  function automatic logic [DT_WIDTH-1:0] dt_load(input logic [DT_WIDTH-1:0] dly);
    if (dly == {DT_WIDTH{1'b0}}) begin
      dt_load = {DT_WIDTH{1'b0}};
    end else begin
      dt_load = dly - DT_WIDTH'(1);
    end
  endfunction

  // Next-state and dead-band counter; fault outranks disable, which outranks normal flow.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    swallow_s = 1'b0;
    if (fault) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      if (fault_clr) begin
        state_d = ST_OFF;
      end else begin
        state_d = ST_FAULT;
      end
    end else if (!enable) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          if (pwm_q) begin
            state_d = ST_DT_TO_HS;
            cnt_d   = dt_load(rise_dly);
          end else begin
            state_d = ST_DT_TO_LS;
            cnt_d   = dt_load(fall_dly);
          end
        end
        ST_LS_ON: begin
          if (pwm_q) begin
            state_d = ST_DT_TO_HS;
            cnt_d   = dt_load(rise_dly);
          end else begin
            state_d = ST_LS_ON;
          end
        end
        ST_HS_ON: begin
          if (!pwm_q) begin
            state_d = ST_DT_TO_LS;
            cnt_d   = dt_load(fall_dly);
          end else begin
            state_d = ST_HS_ON;
          end
        end
        // The returning side skips the dead band: the opposite gate never turned on.
        ST_DT_TO_HS: begin
          if (!pwm_q) begin
            state_d   = ST_LS_ON;
            swallow_s = 1'b1;
          end else if (cnt_q == {DT_WIDTH{1'b0}}) begin
            state_d = ST_HS_ON;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        ST_DT_TO_LS: begin
          if (pwm_q) begin
            state_d   = ST_HS_ON;
            swallow_s = 1'b1;
          end else if (cnt_q == {DT_WIDTH{1'b0}}) begin
            state_d = ST_LS_ON;
          end else begin
            cnt_d = cnt_q - DT_WIDTH'(1);
          end
        end
        default: begin
          state_d = ST_OFF;
        end
      endcase
    end
  end

  // State, input register and outputs all update on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_OFF;
      cnt_q           <= {DT_WIDTH{1'b0}};
      pwm_q           <= 1'b0;
      hs_q            <= 1'b0;
      ls_q            <= 1'b0;
      fault_latched_q <= 1'b0;
      short_pulse_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pwm_q           <= pwm_in;
      hs_q            <= (state_d == ST_HS_ON);
      ls_q            <= (state_d == ST_LS_ON);
      fault_latched_q <= (state_d == ST_FAULT);
      short_pulse_q   <= swallow_s;
    end
  end

  assign hs            = hs_q;
  assign ls            = ls_q;
  assign fault_latched = fault_latched_q;
  assign short_pulse   = short_pulse_q;

endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime: each driven cycle queues the expected {hs,ls,fault_latched,short_pulse}
// after the next edge; a monitor pops and compares one entry per clock.
module tb_pwm_deadtime;

  logic       clk = 1'b0;
  logic       reset, pwm_in, enable, fault, fault_clr;
  logic [7:0] rise_dly, fall_dly;
  logic       hs, ls, fault_latched, short_pulse;

  typedef struct {
    string      tag;
    logic [3:0] v;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pwm_deadtime #(.DT_WIDTH(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .pwm_in        (pwm_in),
    .enable        (enable),
    .rise_dly      (rise_dly),
    .fall_dly      (fall_dly),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .hs            (hs),
    .ls            (ls),
    .fault_latched (fault_latched),
    .short_pulse   (short_pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Queue n cycles of the same expectation; inputs are changed by the caller at negedges.
  task automatic cyc(input int n, input string tag, input logic [3:0] v);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.tag = tag;
      e.v   = v;
      exp_q.push_back(e);
      @(negedge clk);
    end
  endtask

  // Monitor: one expectation per edge, sampled just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check(mon_e.tag, {28'd0, hs, ls, fault_latched, short_pulse}, {28'd0, mon_e.v});
      check("excl", {31'd0, hs & ls}, 32'd0);
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; pwm_in = 1'b0; fault = 1'b0; fault_clr = 1'b0;
    rise_dly = 8'd3; fall_dly = 8'd4;
    cyc(2, "reset", 4'b0000);

    // start-up: full dead band before the first gate
    reset = 1'b0; enable = 1'b1;
    cyc(4, "start_dt", 4'b0000);
    cyc(3, "start_ls", 4'b0100);

    // normal edges
    rise_dly = 8'd3; fall_dly = 8'd2; pwm_in = 1'b1;
    cyc(1, "rise_ls", 4'b0100);
    cyc(3, "rise_dt", 4'b0000);
    cyc(6, "rise_hs", 4'b1000);
    pwm_in = 1'b0;
    cyc(1, "fall_hs", 4'b1000);
    cyc(2, "fall_dt", 4'b0000);
    cyc(3, "fall_ls", 4'b0100);

    // zero delays behave as one clock
    rise_dly = 8'd0; fall_dly = 8'd0; pwm_in = 1'b1;
    cyc(1, "z_rise_ls", 4'b0100);
    cyc(1, "z_rise_dt", 4'b0000);
    cyc(3, "z_hs", 4'b1000);
    pwm_in = 1'b0;
    cyc(1, "z_fall_hs", 4'b1000);
    cyc(1, "z_fall_dt", 4'b0000);
    cyc(3, "z_ls", 4'b0100);

    // short high pulse swallowed on the rising side
    rise_dly = 8'd5; fall_dly = 8'd2; pwm_in = 1'b1;
    cyc(1, "sp_ls", 4'b0100);
    cyc(1, "sp_dt", 4'b0000);
    pwm_in = 1'b0;
    cyc(1, "sp_dt2", 4'b0000);
    cyc(1, "sp_strobe", 4'b0101);
    cyc(3, "sp_ls_back", 4'b0100);

    // short low pulse swallowed on the falling side
    rise_dly = 8'd1; fall_dly = 8'd3; pwm_in = 1'b1;
    cyc(1, "h_ls", 4'b0100);
    cyc(1, "h_dt", 4'b0000);
    cyc(3, "h_hs", 4'b1000);
    pwm_in = 1'b0;
    cyc(1, "hsw_hs", 4'b1000);
    pwm_in = 1'b1;
    cyc(1, "hsw_dt", 4'b0000);
    cyc(1, "hsw_strobe", 4'b1001);
    cyc(2, "hsw_hs_back", 4'b1000);

    // fault latch, clear blocked while fault held, then clean restart
    fault = 1'b1;
    cyc(1, "flt_set", 4'b0010);
    fault = 1'b0;
    cyc(2, "flt_hold", 4'b0010);
    fault = 1'b1; fault_clr = 1'b1;
    cyc(2, "flt_both", 4'b0010);
    fault = 1'b0;
    cyc(1, "flt_clr", 4'b0000);
    fault_clr = 1'b0;
    cyc(1, "flt_dt", 4'b0000);
    cyc(2, "flt_hs", 4'b1000);

    // delay change mid band has no effect
    fall_dly = 8'd2; pwm_in = 1'b0;
    cyc(1, "dc_hs", 4'b1000);
    cyc(2, "dc_dt", 4'b0000);
    cyc(2, "dc_ls", 4'b0100);
    rise_dly = 8'd8; pwm_in = 1'b1;
    cyc(1, "dc_ls2", 4'b0100);
    cyc(1, "dc_band", 4'b0000);
    rise_dly = 8'd1;
    cyc(7, "dc_band", 4'b0000);
    cyc(2, "dc_hs2", 4'b1000);

    // disable mid band, then re-enable reloads the full band
    fall_dly = 8'd5; pwm_in = 1'b0;
    cyc(1, "dis_hs", 4'b1000);
    cyc(2, "dis_band", 4'b0000);
    enable = 1'b0;
    cyc(3, "dis_off", 4'b0000);
    enable = 1'b1;
    cyc(5, "dis_reload", 4'b0000);
    cyc(2, "dis_ls", 4'b0100);

    // disable from an ON state drops the gate on the next edge
    enable = 1'b0;
    cyc(1, "dis_ls_off", 4'b0000);
    enable = 1'b1;
    cyc(5, "dis2_band", 4'b0000);
    cyc(1, "dis2_ls", 4'b0100);

    // reset mid-operation
    reset = 1'b1;
    cyc(1, "rst_mid", 4'b0000);
    reset = 1'b0; enable = 1'b0;
    cyc(1, "rst_off", 4'b0000);

    @(posedge clk);
    #2;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_deadtime.md
# pwm_deadtime

Dead-time insertion stage that sits directly downstream of the PWM generator. It consumes a single PWM waveform (the equal-area or proportional output) and drives a complementary high-side/low-side gate pair. Between the two sides it inserts programmable dead bands, swallows pulses shorter than the dead band, and latches a hard fault shutdown. Both gate outputs are registered and glitch-free.

## Interface
- `DT_WIDTH`, default 8: width of the dead-time delay values.
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `pwm_in`  in  1  PWM waveform from the PWM generator; registered once internally as `pwm_q`.
- `enable`  in  1  1 = drive the gates; 0 = both gates off.
- `rise_dly`  in  DT_WIDTH  dead band before `hs` turns on, in clocks.
- `fall_dly`  in  DT_WIDTH  dead band before `ls` turns on, in clocks.
- `fault`  in  1  level fault request; forces immediate shutdown.
- `fault_clr`  in  1  clears the latched fault.
- `hs`  out  1  high-side gate (follows `pwm_q`=1).
- `ls`  out  1  low-side gate (follows `pwm_q`=0).
- `fault_latched`  out  1  high while in the FAULT state.
- `short_pulse`  out  1  one-cycle strobe when a pulse is swallowed.

## Operation
- **States:** OFF, LS_ON, DT_TO_HS, HS_ON, DT_TO_LS, FAULT.
- **Outputs:** `hs`=1 only in HS_ON; `ls`=1 only in LS_ON; both are 0 in every other state. `hs` and `ls` are never 1 together, in any cycle.
- **Reset:** state=OFF, `pwm_q`=0, counter=0, `hs`=0, `ls`=0, `fault_latched`=0, `short_pulse`=0.
- **Priority, highest first:** reset > `fault` > `enable`=0 > normal transitions.
- **Fault:**
  - `fault`=1 in any state → FAULT next cycle.
  - FAULT → OFF only when `fault_clr`=1 and `fault`=0 in the same cycle.
  - `fault` and `fault_clr` both 1 → remain in FAULT.
- **Disable:** `enable`=0 in any non-FAULT state → OFF next cycle.
- **Leaving OFF** (`enable`=1):
  - `pwm_q`=1 → DT_TO_HS.
  - `pwm_q`=0 → DT_TO_LS.
  - A full dead band is therefore always inserted before the first gate turns on.
- **Edges in the ON states:**
  - LS_ON with `pwm_q`=1 → DT_TO_HS.
  - HS_ON with `pwm_q`=0 → DT_TO_LS.
- **Dead-band counter (DT_WIDTH bits):**
  - On entry to DT_TO_HS, load max(`rise_dly`,1)−1.
  - On entry to DT_TO_LS, load max(`fall_dly`,1)−1.
  - Delay inputs are captured only at entry; changes during a dead band have no effect.
- **In a DT state:**
  - counter==0 → advance to HS_ON or LS_ON respectively.
  - Otherwise decrement.
  - Both gates are low for exactly max(dly,1) cycles; a delay of 0 behaves as 1.
- **Pulse swallowing:**
  - In DT_TO_HS, `pwm_q`=0 → return to LS_ON next cycle and pulse `short_pulse`.
  - In DT_TO_LS, `pwm_q`=1 → return to HS_ON next cycle and pulse `short_pulse`.
  - Swallowing takes precedence over counter expiry in the same cycle.
  - The returning side re-enables with no dead band; this is safe because the opposite gate never asserted.
- **Mid-operation events:** reset, fault or disable during a dead band abandons the count. Re-entry reloads the counter.

## Timing
- `pwm_in` is registered once, so it takes one clock to reach `pwm_q`.
- **Rising edge:** `pwm_in`=1 sampled at edge k.
  - `ls` falls after edge k+1.
  - `hs` rises after edge k+1+max(`rise_dly`,1).
- **Falling edge:** symmetric, with `fall_dly`.
- **Fault:** `fault` sampled at edge k → `hs`=`ls`=0 and `fault_latched`=1 after edge k. The outputs are registered alongside the state, so this is one-edge latency.
- **Disable:** `enable`=0 sampled at edge k → both gates 0 after edge k.
- **`short_pulse`:** asserted for exactly the one cycle following the swallow transition edge.
- **Steady-state duty:** `hs` high time = PWM high time − max(`rise_dly`,1). `ls` high time = PWM low time − max(`fall_dly`,1).

## Test plan
- **Reset and start-up:** reset, then `enable`=1, `pwm_in`=0, `fall_dly`=4 → `hs`=`ls`=0 for 4 cycles after OFF exit, then `ls`=1; `hs` stays 0.
- **Normal edges:** `rise_dly`=3, `fall_dly`=2, `pwm_in` rises before edge 10 and falls before edge 30.
  - `ls`↓ after edge 11, `hs`↑ after edge 14.
  - `hs`↓ after edge 31, `ls`↑ after edge 33.
  - Checker: `hs`&`ls` never 1.
- **Zero delay:** `rise_dly`=0 → exactly 1 both-low cycle before `hs`=1.
- **Short pulse:** `rise_dly`=5, `pwm_in` high for 2 cycles → `hs` never asserts, `ls` returns without a dead band, `short_pulse` is high for exactly 1 cycle.
- **Fault:**
  - `fault` pulses while in HS_ON → `hs`=0 after that edge and `fault_latched`=1.
  - `fault_clr` held together with `fault` → stays latched.
  - `fault_clr` alone → OFF, then dead band, then the gate matching `pwm_q`.
- **Delay change / disable:** change `rise_dly` 8→1 mid dead band → the full 8-cycle band completes. `enable`=0 mid band → both gates 0 on the next edge, and the band is reloaded on re-enable.
